// File: rtl/led_pwm_fader.sv
// rtl/led_pwm_fader.sv - multi-channel LED PWM driver with stepped fade between on/off patterns
// A pattern sets per-LED targets; levels ramp toward them one FADE_STEP per STEP_DIV cycles.
module led_pwm_fader #(
   parameter int N_LEDS    = 5,
   parameter int PWM_BITS  = 8,
   parameter int STEP_DIV  = 1024,
   parameter int FADE_STEP = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [N_LEDS-1:0] pattern_i,
   input  logic              pattern_valid_i,
   output logic              pattern_ready_o,
   output logic [N_LEDS-1:0] led_o,
   output logic              busy_o
);

   localparam int                DIV_W    = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
   localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(STEP_DIV - 1);
   localparam logic [PWM_BITS-1:0] MAX    = {PWM_BITS{1'b1}};
   localparam logic [PWM_BITS:0] MAX_EXT  = {1'b0, {PWM_BITS{1'b1}}};
   localparam logic [PWM_BITS:0] STEP_EXT = (PWM_BITS + 1)'(FADE_STEP);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_FADE = 1'b1
   } state_t;

   state_t                               r_state;
   state_t                               w_state_next;
   logic [PWM_BITS-1:0]                  r_pwm_cnt;
   logic [DIV_W-1:0]                     r_div;
   logic [N_LEDS-1:0][PWM_BITS-1:0]      r_level;
   logic [N_LEDS-1:0]                    r_target;
   logic [N_LEDS-1:0]                    r_led;

   logic                                 w_accept;
   logic                                 w_tick;
   logic                                 w_levels_done;
   logic                                 w_new_done;
   logic [N_LEDS-1:0][PWM_BITS-1:0]      w_level_next;
   logic [N_LEDS-1:0][PWM_BITS:0]        w_up;
   logic [N_LEDS-1:0][PWM_BITS:0]        w_dn;

   assign pattern_ready_o = (r_state == S_IDLE);
   assign busy_o          = (r_state == S_FADE);
   assign w_accept        = pattern_valid_i && pattern_ready_o;
   assign w_tick          = (r_state == S_FADE) && (r_div == DIV_LAST);
   assign led_o           = r_led;

   // Step math is one bit wider so the carry/borrow bit drives the clamp.
   always_comb begin
      w_level_next  = r_level;
      w_up          = '0;
      w_dn          = '0;
      w_levels_done = 1'b1;
      w_new_done    = 1'b1;
      for (int i = 0; i < N_LEDS; i++) begin
         w_up[i] = {1'b0, r_level[i]} + STEP_EXT;
         w_dn[i] = {1'b0, r_level[i]} - STEP_EXT;
         if (r_target[i]) begin
            w_level_next[i] = (w_up[i] > MAX_EXT) ? MAX : w_up[i][PWM_BITS-1:0];
         end else begin
            w_level_next[i] = w_dn[i][PWM_BITS] ? '0 : w_dn[i][PWM_BITS-1:0];
         end
         if (r_level[i] != (r_target[i] ? MAX : '0)) begin
            w_levels_done = 1'b0;
         end
         if (r_level[i] != (pattern_i[i] ? MAX : '0)) begin
            w_new_done = 1'b0;
         end
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_accept && !w_new_done) begin
               w_state_next = S_FADE;
            end
         end
         S_FADE: begin
            if (w_levels_done) begin
               w_state_next = S_IDLE;
            end
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_pwm_cnt <= '0;
         r_div     <= '0;
         r_level   <= '0;
         r_target  <= '0;
         r_led     <= '0;
      end else begin
         r_state   <= w_state_next;
         r_pwm_cnt <= r_pwm_cnt + 1'b1;
         if (w_accept) begin
            r_target <= pattern_i;
            r_div    <= '0;
         end else if (r_state == S_FADE) begin
            r_div <= (r_div == DIV_LAST) ? '0 : r_div + 1'b1;
         end
         if (w_tick) begin
            r_level <= w_level_next;
         end
         for (int i = 0; i < N_LEDS; i++) begin
            r_led[i] <= (r_level[i] == MAX) || (r_level[i] > r_pwm_cnt);
         end
      end
   end

endmodule

// File: tb/tb_led_pwm_fader.sv
// tb/tb_led_pwm_fader.sv - directed self-checking bench for led_pwm_fader
module tb_led_pwm_fader;

   logic       clk;
   logic       rst;
   logic [4:0] pattern_i;
   logic       pattern_valid_i;
   logic       pattern_ready_o;
   logic [4:0] led_o;
   logic       busy_o;

   logic [4:0] d2_pattern_i;
   logic       d2_valid_i;
   logic       d2_ready_o;
   logic [4:0] d2_led_o;
   logic       d2_busy_o;

   int n_checks = 0;
   int n_fail   = 0;

   led_pwm_fader #(.N_LEDS(5), .PWM_BITS(8), .STEP_DIV(4), .FADE_STEP(64)) dut (
      .clk             (clk),
      .rst             (rst),
      .pattern_i       (pattern_i),
      .pattern_valid_i (pattern_valid_i),
      .pattern_ready_o (pattern_ready_o),
      .led_o           (led_o),
      .busy_o          (busy_o)
   );

   // Long step interval so a level-128 plateau outlasts a full PWM period.
   led_pwm_fader #(.N_LEDS(5), .PWM_BITS(8), .STEP_DIV(512), .FADE_STEP(128)) u_duty (
      .clk             (clk),
      .rst             (rst),
      .pattern_i       (d2_pattern_i),
      .pattern_valid_i (d2_valid_i),
      .pattern_ready_o (d2_ready_o),
      .led_o           (d2_led_o),
      .busy_o          (d2_busy_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_levels(input string tag, input int l4, input int l3, input int l2,
                               input int l1, input int l0);
      check({tag, "_lvl4"}, 32'(dut.r_level[4]), l4);
      check({tag, "_lvl3"}, 32'(dut.r_level[3]), l3);
      check({tag, "_lvl2"}, 32'(dut.r_level[2]), l2);
      check({tag, "_lvl1"}, 32'(dut.r_level[1]), l1);
      check({tag, "_lvl0"}, 32'(dut.r_level[0]), l0);
   endtask

   task automatic accept(input logic [4:0] pat);
      pattern_i       = pat;
      pattern_valid_i = 1'b1;
      tick();
      pattern_valid_i = 1'b0;
   endtask

   int steps_up[4]   = '{64, 128, 192, 255};
   int steps_down[4] = '{191, 127, 63, 0};
   int cnt;

   initial begin
      rst             = 1'b1;
      pattern_i       = '0;
      pattern_valid_i = 1'b0;
      d2_pattern_i    = '0;
      d2_valid_i      = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      check("rst_led", 32'(led_o), 0);
      check("rst_ready", 32'(pattern_ready_o), 1);
      check("rst_busy", 32'(busy_o), 0);
      check("rst_pwm", 32'(dut.r_pwm_cnt), 0);

      // Fade-in of alternate LEDs
      accept(5'b10101);
      check("in_busy", 32'(busy_o), 1);
      check("in_target", 32'(dut.r_target), 32'h15);
      repeat (3) tick();
      check_levels("in_pre", 0, 0, 0, 0, 0);
      tick();
      check_levels("in_s1", 64, 0, 64, 0, 64);
      for (int s = 1; s < 4; s++) begin
         repeat (4) tick();
         check_levels($sformatf("in_s%0d", s + 1), steps_up[s], 0, steps_up[s], 0, steps_up[s]);
      end
      check("in_busy16", 32'(busy_o), 1);
      tick();
      check("in_busy17", 32'(busy_o), 0);
      check("in_ready17", 32'(pattern_ready_o), 1);

      cnt = 0;
      for (int c = 0; c < 256; c++) begin
         if (led_o == 5'b10101) cnt++;
         tick();
      end
      check("duty255", cnt, 256);

      // Bring the remaining LEDs up so every level is MAX
      accept(5'b11111);
      check("all_busy", 32'(busy_o), 1);
      for (int s = 0; s < 4; s++) begin
         repeat (4) tick();
         check_levels($sformatf("all_s%0d", s + 1), 255, steps_up[s], 255, steps_up[s], 255);
      end
      tick();
      check("all_idle", 32'(busy_o), 0);

      // Fade-out with an ignored pattern offered mid-fade
      accept(5'b00000);
      check("out_busy", 32'(busy_o), 1);
      pattern_i       = 5'b11111;
      pattern_valid_i = 1'b1;
      tick();
      pattern_valid_i = 1'b0;
      check("out_ign_target", 32'(dut.r_target), 0);
      check("out_ign_busy", 32'(busy_o), 1);
      repeat (3) tick();
      check_levels("out_s1", 191, 191, 191, 191, 191);
      for (int s = 1; s < 4; s++) begin
         repeat (4) tick();
         check_levels($sformatf("out_s%0d", s + 1), steps_down[s], steps_down[s],
                      steps_down[s], steps_down[s], steps_down[s]);
      end
      tick();
      check("out_idle", 32'(busy_o), 0);
      check("out_ready", 32'(pattern_ready_o), 1);
      check("out_led", 32'(led_o), 0);

      accept(5'b00000);
      check("noop_busy", 32'(busy_o), 0);
      check("noop_ready", 32'(pattern_ready_o), 1);
      tick();
      check("noop_busy2", 32'(busy_o), 0);

      // Reset at cycle 6 of a fade, with a concurrent pattern offer
      accept(5'b11111);
      repeat (6) tick();
      check("mid_lvl_pre", 32'(dut.r_level[0]), 64);
      check("mid_busy_pre", 32'(busy_o), 1);
      rst             = 1'b1;
      pattern_i       = 5'b10101;
      pattern_valid_i = 1'b1;
      tick();
      rst             = 1'b0;
      pattern_valid_i = 1'b0;
      check_levels("mid_rst", 0, 0, 0, 0, 0);
      check("mid_led", 32'(led_o), 0);
      check("mid_ready", 32'(pattern_ready_o), 1);
      check("mid_busy", 32'(busy_o), 0);
      check("mid_target", 32'(dut.r_target), 0);
      repeat (8) tick();
      check_levels("mid_hold", 0, 0, 0, 0, 0);
      check("mid_busy_hold", 32'(busy_o), 0);

      // Level-128 duty on the slow instance: plateau spans cycles 512..1023
      d2_pattern_i = 5'b00001;
      d2_valid_i   = 1'b1;
      tick();
      d2_valid_i = 1'b0;
      repeat (522) tick();
      check("duty_busy", 32'(d2_busy_o), 1);
      cnt = 0;
      for (int c = 0; c < 256; c++) begin
         if (d2_led_o[0]) cnt++;
         tick();
      end
      check("duty128", cnt, 128);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
